// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the external SRAM sequencer: one-hot state encodings
// (also decoded by hexDisplay) and the timeout counter width.
package mem_ctrl_pkg;

    localparam int STATE_W   = 12;
    localparam int TIMEOUT_W = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE       = 12'h001,
        READ_ST0   = 12'h002,
        READ_ST1   = 12'h004,
        READ_ST2   = 12'h008,
        READ_WAIT  = 12'h010,
        READ_DONE  = 12'h020,
        WRITE_ST0  = 12'h040,
        WRITE_ST1  = 12'h080,
        WRITE_ST2  = 12'h100,
        WRITE_ST3  = 12'h200,
        WRITE_ST4  = 12'h400,
        WRITE_WAIT = 12'h800
    } state_e;

endpackage

// File: rtl/mem_seq_ctrl_if.sv
// SRAM-side bus of the sequencer: address/data/strobes out, read data and ack back.
interface mem_seq_ctrl_if #(
    parameter int ADDR_W = 20
);

    // Handshake: the controller holds cs_n/oe_n (read) or cs_n (write) asserted in
    // the wait state until it samples mem_ack=1 on a rising clk edge; that edge
    // completes the transfer and mem_rdata is captured on it. No ack means timeout.
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_oe_n;
    logic              mem_cs_n;
    logic              mem_we_n;
    logic              mem_ack;

    modport master (
        output mem_addr, mem_wdata, mem_oe_n, mem_cs_n, mem_we_n,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_addr, mem_wdata, mem_oe_n, mem_cs_n, mem_we_n,
        output mem_rdata, mem_ack
    );

endinterface

// File: rtl/req_edge_det.sv
// Registered rising-edge detector: pulses while the level is high and was low at
// the previous clock, so a held request never retriggers.
module req_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic rise
);

    logic prev_q;
    logic prev_d;

    always_comb prev_d = level;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= 1'b0;
        else        prev_q <= prev_d;
    end

    assign rise = level & ~prev_q;

endmodule

// File: rtl/mem_seq_ctrl.sv
// Sequencing FSM for the asynchronous 16-bit SRAM: steps the strobes through fixed
// setup/strobe/hold phases per request, then waits for mem_ack or times out.
module mem_seq_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 20,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               rd_req,
    input  logic               wr_req,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [15:0]        wdata,
    mem_seq_ctrl_if.master     mem,
    output logic [STATE_W-1:0] state,
    output logic [15:0]        rd_data,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [TIMEOUT_W-1:0] TO_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);

    logic rd_rise;
    logic wr_rise;

    req_edge_det u_rd_edge (.clk(clk), .rst_n(rst_n), .level(rd_req), .rise(rd_rise));
    req_edge_det u_wr_edge (.clk(clk), .rst_n(rst_n), .level(wr_req), .rise(wr_rise));

    state_e               state_q,     state_d;
    logic [TIMEOUT_W-1:0] cnt_q,       cnt_d;
    logic [ADDR_W-1:0]    addr_q,      addr_d;
    logic [15:0]          wdata_q,     wdata_d;
    logic [15:0]          mem_wdata_q, mem_wdata_d;
    logic [15:0]          rd_data_q,   rd_data_d;
    logic                 cs_n_q,      cs_n_d;
    logic                 we_n_q,      we_n_d;
    logic                 oe_n_q,      oe_n_d;
    logic                 done_q,      done_d;
    logic                 err_q,       err_d;
    logic                 timed_out;

    // Ack is tested before the timeout, so an ack on the last allowed cycle wins.
    assign timed_out = (cnt_q == TO_LAST);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rd_data_d = rd_data_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (rd_rise) begin
                    state_d = READ_ST0;
                    addr_d  = addr;
                end else if (wr_rise) begin
                    state_d = WRITE_ST0;
                    addr_d  = addr;
                    wdata_d = wdata;
                end
            end
            READ_ST0: state_d = READ_ST1;
            READ_ST1: state_d = READ_ST2;
            READ_ST2: begin
                state_d = READ_WAIT;
                cnt_d   = '0;
            end
            READ_WAIT: begin
                if (mem.mem_ack) begin
                    rd_data_d = mem.mem_rdata;
                    state_d   = READ_DONE;
                    done_d    = 1'b1;
                end else if (timed_out) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            READ_DONE: if (!rd_req) state_d = IDLE;
            WRITE_ST0: state_d = WRITE_ST1;
            WRITE_ST1: state_d = WRITE_ST2;
            WRITE_ST2: state_d = WRITE_ST3;
            WRITE_ST3: state_d = WRITE_ST4;
            WRITE_ST4: begin
                state_d = WRITE_WAIT;
                cnt_d   = '0;
            end
            WRITE_WAIT: begin
                if (mem.mem_ack) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (timed_out) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + TIMEOUT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Strobes are decoded from the next state so they change with the state.
        cs_n_d      = !(state_d inside {READ_ST1, READ_ST2, READ_WAIT,
                                        WRITE_ST2, WRITE_ST3, WRITE_ST4, WRITE_WAIT});
        oe_n_d      = !(state_d inside {READ_ST2, READ_WAIT});
        we_n_d      = (state_d != WRITE_ST3);
        mem_wdata_d = (state_d inside {WRITE_ST1, WRITE_ST2, WRITE_ST3, WRITE_ST4, WRITE_WAIT})
                      ? wdata_d : 16'h0000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            mem_wdata_q <= '0;
            rd_data_q   <= '0;
            cs_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            mem_wdata_q <= mem_wdata_d;
            rd_data_q   <= rd_data_d;
            cs_n_q      <= cs_n_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign mem.mem_cs_n  = cs_n_q;
    assign mem.mem_we_n  = we_n_q;
    assign mem.mem_oe_n  = oe_n_q;
    assign state         = state_q;
    assign rd_data       = rd_data_q;
    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_mem_seq_ctrl.sv
// Directed bench for mem_seq_ctrl: an operation/step-offset reference model checked
// every cycle, plus literal expectations pinned for each scenario.
module tb_mem_seq_ctrl;
    import mem_ctrl_pkg::*;

    localparam int ADDR_W = 20;
    localparam int TO     = 4;

    logic              clk    = 1'b0;
    logic              rst_n  = 1'b0;
    logic              rd_req = 1'b0;
    logic              wr_req = 1'b0;
    logic [ADDR_W-1:0] addr   = '0;
    logic [15:0]       wdata  = '0;
    logic [11:0]       state;
    logic [15:0]       rd_data;
    logic              busy, done, err;

    mem_seq_ctrl_if #(.ADDR_W(ADDR_W)) mif ();

    mem_seq_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst_n(rst_n), .rd_req(rd_req), .wr_req(wr_req), .addr(addr),
        .wdata(wdata), .mem(mif), .state(state), .rd_data(rd_data), .busy(busy),
        .done(done), .err(err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
    endtask

    // ---------------- reference model ----------------
    // An operation is tracked as (kind, step offset since acceptance, wait cycles);
    // every output follows from those numbers.
    typedef enum int {M_IDLE, M_READ, M_WRITE, M_RDONE} mop_e;
    mop_e              m_op      = M_IDLE;
    int                m_k       = 0;
    int                m_w       = 0;
    logic [ADDR_W-1:0] m_addr    = '0;
    logic [15:0]       m_wdata   = '0;
    logic [15:0]       m_rd      = '0;
    logic              m_done    = 1'b0;
    logic              m_err     = 1'b0;
    logic              m_prev_rd = 1'b0;
    logic              m_prev_wr = 1'b0;

    state_e rd_steps [4] = '{READ_ST0, READ_ST1, READ_ST2, READ_WAIT};
    state_e wr_steps [6] = '{WRITE_ST0, WRITE_ST1, WRITE_ST2, WRITE_ST3, WRITE_ST4, WRITE_WAIT};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_op <= M_IDLE; m_k <= 0; m_w <= 0; m_addr <= '0; m_wdata <= '0; m_rd <= '0;
            m_done <= 1'b0; m_err <= 1'b0; m_prev_rd <= 1'b0; m_prev_wr <= 1'b0;
        end else begin
            m_done <= 1'b0;
            m_err  <= 1'b0;
            case (m_op)
                M_IDLE: begin
                    if (rd_req && !m_prev_rd) begin
                        m_op <= M_READ; m_k <= 0; m_addr <= addr;
                    end else if (wr_req && !m_prev_wr) begin
                        m_op <= M_WRITE; m_k <= 0; m_addr <= addr; m_wdata <= wdata;
                    end
                end
                M_READ, M_WRITE: begin
                    if (m_k < ((m_op == M_READ) ? 3 : 5)) begin
                        m_k <= m_k + 1;
                        m_w <= 0;
                    end else if (mif.mem_ack) begin
                        m_done <= 1'b1;
                        if (m_op == M_READ) begin
                            m_rd <= mif.mem_rdata;
                            m_op <= M_RDONE;
                        end else begin
                            m_op <= M_IDLE;
                        end
                    end else if (m_w == TO - 1) begin
                        m_err <= 1'b1;
                        m_op  <= M_IDLE;
                    end else begin
                        m_w <= m_w + 1;
                    end
                end
                M_RDONE: if (!rd_req) m_op <= M_IDLE;
                default: m_op <= M_IDLE;
            endcase
            m_prev_rd <= rd_req;
            m_prev_wr <= wr_req;
        end
    end

    // ---------------- per-cycle compare ----------------
    state_e e_state;
    logic   e_cs_n, e_oe_n, e_we_n;

    always @(negedge clk) begin
        case (m_op)
            M_READ:  e_state = rd_steps[m_k];
            M_WRITE: e_state = wr_steps[m_k];
            M_RDONE: e_state = READ_DONE;
            default: e_state = IDLE;
        endcase
        e_cs_n = !((m_op == M_READ && m_k >= 1) || (m_op == M_WRITE && m_k >= 2));
        e_oe_n = !(m_op == M_READ && m_k >= 2);
        e_we_n = !(m_op == M_WRITE && m_k == 3);
        chk("cyc_state",    32'(state),         32'(e_state));
        chk("cyc_onehot",   32'($onehot(state)), 32'd1);
        chk("cyc_busy",     32'(busy),          32'(m_op != M_IDLE));
        chk("cyc_done",     32'(done),          32'(m_done));
        chk("cyc_err",      32'(err),           32'(m_err));
        chk("cyc_cs_n",     32'(mif.mem_cs_n),  32'(e_cs_n));
        chk("cyc_oe_n",     32'(mif.mem_oe_n),  32'(e_oe_n));
        chk("cyc_we_n",     32'(mif.mem_we_n),  32'(e_we_n));
        chk("cyc_mem_addr", 32'(mif.mem_addr),  32'(m_addr));
        chk("cyc_rd_data",  32'(rd_data),       32'(m_rd));
        if (m_op == M_WRITE && m_k >= 1)
            chk("cyc_mem_wdata", 32'(mif.mem_wdata), 32'(m_wdata));
    end

    // ---------------- driver tasks ----------------
    logic [11:0] seq_q[$];
    logic [11:0] exp_q[$];

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #2;
    endtask

    // Raises one request, then services the wait state: ack on wait cycle ack_at
    // (never if negative); bounce drops and re-raises rd_req inside READ_WAIT.
    task automatic run_op(input bit is_rd, input int ack_at, input bit bounce,
                          input logic [15:0] rdata, output int cyc, output int n_done,
                          output int n_err, output int n_wait, output int n_we,
                          output int n_wr_states, output int n_wd_bad);
        int waits = 0;
        bit fin   = 1'b0;
        cyc = 0; n_done = 0; n_err = 0; n_wait = 0; n_we = 0; n_wr_states = 0; n_wd_bad = 0;
        seq_q.delete();
        mif.mem_rdata = rdata;
        if (is_rd) rd_req = 1'b1;
        else       wr_req = 1'b1;
        while (!fin && cyc < 40) begin
            tick();
            cyc++;
            seq_q.push_back(state);
            n_done += int'(done);
            n_err  += int'(err);
            n_we   += int'(!mif.mem_we_n);
            if (state inside {WRITE_ST0, WRITE_ST1, WRITE_ST2, WRITE_ST3, WRITE_ST4, WRITE_WAIT})
                n_wr_states++;
            if (state inside {WRITE_ST1, WRITE_ST2, WRITE_ST3, WRITE_ST4, WRITE_WAIT} &&
                mif.mem_wdata !== wdata)
                n_wd_bad++;
            mif.mem_ack = 1'b0;
            if (state == READ_WAIT || state == WRITE_WAIT) begin
                mif.mem_ack = (waits == ack_at);
                if (bounce) rd_req = (waits != 0);
                waits++;
                n_wait++;
            end
            fin = (state == IDLE || state == READ_DONE);
        end
        mif.mem_ack = 1'b0;
        chk("op_terminates", 32'(fin), 32'd1);
    endtask

    // ---------------- directed scenarios ----------------
    int cyc, nd, ne, nw, nwe, nws, nwd;

    initial begin
        mif.mem_rdata = '0;
        mif.mem_ack   = 1'b0;
        tick(3);
        chk("rst_state",  32'(state),          32'(IDLE));
        chk("rst_cs_n",   32'(mif.mem_cs_n),   32'd1);
        chk("rst_we_n",   32'(mif.mem_we_n),   32'd1);
        chk("rst_oe_n",   32'(mif.mem_oe_n),   32'd1);
        chk("rst_addr",   32'(mif.mem_addr),   32'd0);
        chk("rst_wdata",  32'(mif.mem_wdata),  32'd0);
        chk("rst_rddata", 32'(rd_data),        32'd0);
        chk("rst_busy",   32'(busy),           32'd0);
        chk("rst_done",   32'(done),           32'd0);
        chk("rst_err",    32'(err),            32'd0);
        rst_n = 1'b1;
        tick(2);

        // reset asserted in the middle of the write strobe
        addr = 20'h00777; wdata = 16'hA5A5; wr_req = 1'b1;
        tick(4);
        chk("t1_in_st3", 32'(state),        32'(WRITE_ST3));
        chk("t1_we_low", 32'(mif.mem_we_n), 32'd0);
        #1 rst_n = 1'b0;
        #1;
        chk("t1_we_n", 32'(mif.mem_we_n), 32'd1);
        chk("t1_cs_n", 32'(mif.mem_cs_n), 32'd1);
        chk("t1_state", 32'(state),       32'(IDLE));
        chk("t1_busy", 32'(busy),         32'd0);
        chk("t1_addr", 32'(mif.mem_addr), 32'd0);
        wr_req = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(2);

        // read, ack on third wait cycle
        addr = 20'h00012;
        run_op(1'b1, 2, 1'b0, 16'hBEEF, cyc, nd, ne, nw, nwe, nws, nwd);
        exp_q = '{READ_ST0, READ_ST1, READ_ST2, READ_WAIT, READ_WAIT, READ_WAIT, READ_DONE};
        chk("t2_seq_len", 32'(seq_q.size()), 32'd7);
        for (int i = 0; i < 7 && i < seq_q.size(); i++)
            chk($sformatf("t2_seq%0d", i), 32'(seq_q[i]), 32'(exp_q[i]));
        chk("t2_latency", 32'(cyc - 1), 32'd6);
        chk("t2_rd_data", 32'(rd_data), 32'hBEEF);
        chk("t2_mem_addr", 32'(mif.mem_addr), 32'h00012);
        tick(3);
        chk("t2_hold_done_state", 32'(state), 32'(READ_DONE));
        rd_req = 1'b0;
        tick();
        chk("t2_idle", 32'(state), 32'(IDLE));
        chk("t2_done_count", 32'(nd), 32'd1);

        // write, ack on first wait cycle
        addr = 20'h00034; wdata = 16'h1234;
        run_op(1'b0, 0, 1'b0, 16'h0000, cyc, nd, ne, nw, nwe, nws, nwd);
        chk("t3_we_cycles", 32'(nwe), 32'd1);
        chk("t3_done",      32'(nd),  32'd1);
        chk("t3_err",       32'(ne),  32'd0);
        chk("t3_latency",   32'(cyc - 1), 32'd6);
        chk("t3_wdata_bad", 32'(nwd), 32'd0);
        chk("t3_end_state", 32'(state), 32'(IDLE));
        chk("t3_mem_addr",  32'(mif.mem_addr), 32'h00034);
        wr_req = 1'b0;
        tick();

        // read with no ack: timeout
        addr = 20'h00056;
        run_op(1'b1, -1, 1'b0, 16'hDEAD, cyc, nd, ne, nw, nwe, nws, nwd);
        chk("t4_waits",   32'(nw),  32'd4);
        chk("t4_err",     32'(ne),  32'd1);
        chk("t4_done",    32'(nd),  32'd0);
        chk("t4_cycles",  32'(cyc), 32'd8);
        chk("t4_rd_data", 32'(rd_data), 32'hBEEF);
        chk("t4_state",   32'(state), 32'(IDLE));
        rd_req = 1'b0;
        tick();

        // simultaneous edges: read wins, held write never starts
        addr = 20'h00078; wr_req = 1'b1;
        run_op(1'b1, 1, 1'b0, 16'h5A5A, cyc, nd, ne, nw, nwe, nws, nwd);
        chk("t5_no_write", 32'(nws), 32'd0);
        chk("t5_done",     32'(nd),  32'd1);
        chk("t5_cycles",   32'(cyc), 32'd6);
        chk("t5_rd_data",  32'(rd_data), 32'h5A5A);
        rd_req = 1'b0;
        tick(4);
        chk("t5_idle", 32'(state), 32'(IDLE));
        chk("t5_busy", 32'(busy),  32'd0);
        wr_req = 1'b0;
        tick();

        // ack on the last timeout cycle, rd_req re-edge inside READ_WAIT
        addr = 20'h0009A;
        run_op(1'b1, 3, 1'b1, 16'hC3C3, cyc, nd, ne, nw, nwe, nws, nwd);
        chk("t6_waits",   32'(nw),  32'd4);
        chk("t6_done",    32'(nd),  32'd1);
        chk("t6_err",     32'(ne),  32'd0);
        chk("t6_cycles",  32'(cyc), 32'd8);
        chk("t6_rd_data", 32'(rd_data), 32'hC3C3);
        rd_req = 1'b0;
        tick();
        chk("t6_idle", 32'(state), 32'(IDLE));
        tick(3);
        chk("t6_no_rerun", 32'(state), 32'(IDLE));
        chk("t6_busy",     32'(busy),  32'd0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
